// File: rtl/timer_regbank_cmp_if.sv
// ---------------------------------------------------------------------------
// timer_regbank_cmp_if
// Register-access bus between the APB slave FSM (master side) and the timer
// register bank (slave side).
//   addr   byte address (ADDR_W bits), word aligned
//   wr_en  one-cycle write strobe
//   rd_en  one-cycle read strobe
//   wdata  32-bit write data
//   wstrb  byte enables for writes
//   rdata  registered read data (one cycle after rd_en)
//   err    registered access-error pulse (one cycle after the access)
// ---------------------------------------------------------------------------
interface timer_regbank_cmp_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic              rd_en;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output addr, wr_en, rd_en, wdata, wstrb,
        input  rdata, err
    );

    modport slave (
        input  addr, wr_en, rd_en, wdata, wstrb,
        output rdata, err
    );
endinterface

// File: rtl/timer_regbank_cmp.sv
// ---------------------------------------------------------------------------
// timer_regbank_cmp
// Register bank and 64-bit counter core of the APB timer: byte-strobed
// writes, registered reads, a prescaled up-counter, NUM_CMP compare channels
// with W1C sticky status, and a combined interrupt.
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous reset, active high
//   bus   register-access bus (slave modport): addr/wr_en/rd_en/wdata/wstrb
//         in, rdata/err out (both registered)
//   irq   |(TISR & TIER), combinational from registers
//   cnt   current counter value {TDR1,TDR0}
// Register map (reserved bits read 0):
//   0x00 TCR  [0] timer_en, [1] div_en, [8+:DIV_W] div_val
//   0x04 TDR0  0x08 TDR1  0x0C TIER  0x10 TISR (W1C)
//   0x20+8k TCMP_LO[k], 0x24+8k TCMP_HI[k]
// ---------------------------------------------------------------------------
module timer_regbank_cmp #(
    parameter int NUM_CMP = 2,
    parameter int ADDR_W  = 12,
    parameter int DIV_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    timer_regbank_cmp_if.slave  bus,
    output logic                irq,
    output logic [63:0]         cnt
);

    // Prescale counter must reach 2^(2^DIV_W - 1) - 1, hence 2^DIV_W bits.
    localparam int          DIVC_W   = 2 ** DIV_W;
    localparam logic [31:0] TCR_MASK = 32'h3 | (((32'h1 << DIV_W) - 32'h1) << 8);

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]        tcr_reg,     tcr_next;
    logic [63:0]        cnt_reg,     cnt_next;
    logic [NUM_CMP-1:0] tier_reg,    tier_next;
    logic [NUM_CMP-1:0] tisr_reg,    tisr_next;
    logic [63:0]        tcmp_reg     [NUM_CMP];
    logic [63:0]        tcmp_next    [NUM_CMP];
    logic [DIVC_W-1:0]  div_cnt_reg, div_cnt_next;
    logic [31:0]        rdata_reg,   rdata_next;
    logic               err_reg,     err_next;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic               sel_tcr, sel_tdr0, sel_tdr1, sel_tier, sel_tisr;
    logic [NUM_CMP-1:0] sel_cmp_lo, sel_cmp_hi;
    logic [NUM_CMP-1:0] match;
    logic               aligned, mapped, wr_ok, rd_ok, acc_err;
    logic [31:0]        wmask, w1c_bits;

    assign sel_tcr  = (bus.addr == ADDR_W'(32'h00));
    assign sel_tdr0 = (bus.addr == ADDR_W'(32'h04));
    assign sel_tdr1 = (bus.addr == ADDR_W'(32'h08));
    assign sel_tier = (bus.addr == ADDR_W'(32'h0C));
    assign sel_tisr = (bus.addr == ADDR_W'(32'h10));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CMP; gi++) begin : g_cmp
            assign sel_cmp_lo[gi] = (bus.addr == ADDR_W'(32'h20 + 32'(8 * gi)));
            assign sel_cmp_hi[gi] = (bus.addr == ADDR_W'(32'h24 + 32'(8 * gi)));
            // Compare runs on the registered count regardless of timer_en.
            assign match[gi]      = (cnt_reg == tcmp_reg[gi]);
        end
    endgenerate

    assign aligned = (bus.addr[1:0] == 2'b00);
    assign mapped  = aligned & (sel_tcr | sel_tdr0 | sel_tdr1 | sel_tier | sel_tisr |
                                (|sel_cmp_lo) | (|sel_cmp_hi));
    // Simultaneous read and write is illegal and touches nothing.
    assign acc_err = (bus.wr_en | bus.rd_en) & (~mapped | (bus.wr_en & bus.rd_en));
    assign wr_ok   = bus.wr_en & ~bus.rd_en & mapped;
    assign rd_ok   = bus.rd_en & ~bus.wr_en & mapped;
    assign wmask   = byte_mask(bus.wstrb);
    assign w1c_bits = bus.wdata & wmask;

    // ------------------------------------------------------------------
    // Prescaler and counter
    // ------------------------------------------------------------------
    logic              timer_en, div_en, tick;
    logic [DIV_W-1:0]  div_val;
    logic [DIVC_W-1:0] div_limit;

    assign timer_en  = tcr_reg[0];
    assign div_en    = tcr_reg[1];
    assign div_val   = tcr_reg[8 +: DIV_W];
    assign div_limit = (DIVC_W'(1) << div_val) - DIVC_W'(1);
    assign tick      = ~div_en | (div_cnt_reg == div_limit);

    always_comb begin
        tcr_next = tcr_reg;
        if (wr_ok && sel_tcr) begin
            tcr_next = ((tcr_reg & ~wmask) | (bus.wdata & wmask)) & TCR_MASK;
        end

        // Any TCR write restarts the prescale period.
        div_cnt_next = '0;
        if (timer_en && div_en && !(wr_ok && sel_tcr) && !tick) begin
            div_cnt_next = div_cnt_reg + DIVC_W'(1);
        end

        // A software write to either half suppresses that cycle's increment.
        cnt_next = cnt_reg;
        if (wr_ok && (sel_tdr0 || sel_tdr1)) begin
            if (sel_tdr0) cnt_next[31:0]  = (cnt_reg[31:0]  & ~wmask) | (bus.wdata & wmask);
            if (sel_tdr1) cnt_next[63:32] = (cnt_reg[63:32] & ~wmask) | (bus.wdata & wmask);
        end else if (timer_en && tick) begin
            cnt_next = cnt_reg + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt enable, status, compare values
    // ------------------------------------------------------------------
    always_comb begin
        logic [31:0] tier_wide;
        tier_wide = (32'(tier_reg) & ~wmask) | (bus.wdata & wmask);
        tier_next = tier_reg;
        if (wr_ok && sel_tier) begin
            tier_next = tier_wide[NUM_CMP-1:0];
        end

        // Set has priority over a same-cycle clear.
        tisr_next = tisr_reg | match;
        if (wr_ok && sel_tisr) begin
            tisr_next = (tisr_reg & ~w1c_bits[NUM_CMP-1:0]) | match;
        end

        for (int k = 0; k < NUM_CMP; k++) begin
            tcmp_next[k] = tcmp_reg[k];
            if (wr_ok && sel_cmp_lo[k]) begin
                tcmp_next[k][31:0] = (tcmp_reg[k][31:0] & ~wmask) | (bus.wdata & wmask);
            end
            if (wr_ok && sel_cmp_hi[k]) begin
                tcmp_next[k][63:32] = (tcmp_reg[k][63:32] & ~wmask) | (bus.wdata & wmask);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and response
    // ------------------------------------------------------------------
    always_comb begin
        logic [31:0] rd_mux;
        rd_mux = '0;
        if (sel_tcr)  rd_mux = tcr_reg;
        if (sel_tdr0) rd_mux = cnt_reg[31:0];
        if (sel_tdr1) rd_mux = cnt_reg[63:32];
        if (sel_tier) rd_mux = 32'(tier_reg);
        if (sel_tisr) rd_mux = 32'(tisr_reg);
        for (int k = 0; k < NUM_CMP; k++) begin
            if (sel_cmp_lo[k]) rd_mux = tcmp_reg[k][31:0];
            if (sel_cmp_hi[k]) rd_mux = tcmp_reg[k][63:32];
        end
        rdata_next = rd_ok ? rd_mux : 32'h0;
        err_next   = acc_err;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tcr_reg     <= '0;
            cnt_reg     <= '0;
            tier_reg    <= '0;
            tisr_reg    <= '0;
            div_cnt_reg <= '0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
            for (int k = 0; k < NUM_CMP; k++) begin
                tcmp_reg[k] <= '1;
            end
        end else begin
            tcr_reg     <= tcr_next;
            cnt_reg     <= cnt_next;
            tier_reg    <= tier_next;
            tisr_reg    <= tisr_next;
            div_cnt_reg <= div_cnt_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
            for (int k = 0; k < NUM_CMP; k++) begin
                tcmp_reg[k] <= tcmp_next[k];
            end
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.err   = err_reg;
    assign irq       = |(tisr_reg & tier_reg);
    assign cnt       = cnt_reg;

endmodule

// File: tb/tb_timer_regbank_cmp.sv
// ---------------------------------------------------------------------------
// tb_timer_regbank_cmp
// Directed bench for timer_regbank_cmp (NUM_CMP=2, ADDR_W=12, DIV_W=4).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_timer_regbank_cmp;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq;
    logic [63:0] cnt;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] rd;
    logic        e;

    always #5 clk = ~clk;

    timer_regbank_cmp_if #(.ADDR_W(12)) bus_if ();

    timer_regbank_cmp #(
        .NUM_CMP (2),
        .ADDR_W  (12),
        .DIV_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave),
        .irq (irq),
        .cnt (cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, act);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic er);
        @(negedge clk);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.wstrb = s;
        bus_if.wr_en = 1'b1;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
        er = bus_if.err;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output logic er);
        @(negedge clk);
        bus_if.addr  = a;
        bus_if.rd_en = 1'b1;
        @(negedge clk);
        bus_if.rd_en = 1'b0;
        d  = bus_if.rdata;
        er = bus_if.err;
    endtask

    logic [11:0] map_addr [9];
    logic [31:0] map_rst  [9];

    initial begin
        map_addr = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                     12'h020, 12'h024, 12'h028, 12'h02C};
        map_rst  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                     32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

        rst          = 1'b1;
        bus_if.addr  = '0;
        bus_if.wdata = '0;
        bus_if.wstrb = '0;
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_rdata", bus_if.rdata, 0);
        check_val("rst_err",   bus_if.err,   0);
        check_val("rst_irq",   irq,          0);
        check_val("rst_cnt",   cnt,          0);
        rst = 1'b0;

        // 1. reset values of every mapped register
        for (int i = 0; i < 9; i++) begin
            bus_read(map_addr[i], rd, e);
            check_val($sformatf("reset_read_%03h", map_addr[i]), rd, map_rst[i]);
            check_val($sformatf("reset_err_%03h", map_addr[i]), e, 0);
        end
        @(negedge clk);
        check_val("idle_rdata_zero", bus_if.rdata, 0);

        // 2. undivided count, one per cycle
        bus_write(12'h000, 32'h1, 4'hF, e);
        bus_if.addr  = 12'h004;
        bus_if.rd_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_val($sformatf("nodiv_tdr0_%0d", k), bus_if.rdata, 64'(k - 1));
        end
        bus_if.rd_en = 1'b0;

        // divide by 8
        bus_write(12'h000, 32'h302, 4'hF, e);
        bus_write(12'h004, 32'h0, 4'hF, e);
        bus_write(12'h008, 32'h0, 4'hF, e);
        bus_write(12'h000, 32'h303, 4'hF, e);
        bus_if.addr  = 12'h004;
        bus_if.rd_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check_val($sformatf("div8_tdr0_%0d", k), bus_if.rdata, 64'((k - 1) / 8));
        end
        bus_if.rd_en = 1'b0;

        // 3. carry from TDR0 into TDR1
        bus_write(12'h000, 32'h0, 4'hF, e);
        bus_write(12'h004, 32'hFFFFFFFE, 4'hF, e);
        bus_write(12'h008, 32'h0, 4'hF, e);
        bus_write(12'h000, 32'h1, 4'hF, e);
        check_val("carry_cnt0", cnt, 64'h0000_0000_FFFF_FFFE);
        @(negedge clk);
        check_val("carry_cnt1", cnt, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        check_val("carry_cnt2", cnt, 64'h0000_0001_0000_0000);
        bus_write(12'h000, 32'h0, 4'hF, e);
        bus_read(12'h008, rd, e);
        check_val("carry_tdr1", rd, 1);
        bus_read(12'h004, rd, e);
        check_val("carry_tdr0", rd, 2);

        // 64-bit wrap
        bus_write(12'h004, 32'hFFFFFFFF, 4'hF, e);
        bus_write(12'h008, 32'hFFFFFFFF, 4'hF, e);
        bus_write(12'h000, 32'h1, 4'hF, e);
        check_val("wrap_cnt_max", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        check_val("wrap_cnt_zero", cnt, 0);
        bus_write(12'h000, 32'h0, 4'hF, e);
        // both compares (reset all ones) matched during the wrap; TIER is 0
        check_val("wrap_irq_masked", irq, 0);
        bus_read(12'h010, rd, e);
        check_val("wrap_tisr", rd, 3);
        bus_write(12'h010, 32'h3, 4'hF, e);
        bus_read(12'h010, rd, e);
        check_val("tisr_cleared", rd, 0);

        // 4. compare channel 0 at cnt=5
        bus_write(12'h020, 32'h5, 4'hF, e);
        bus_write(12'h024, 32'h0, 4'hF, e);
        bus_write(12'h00C, 32'h1, 4'hF, e);
        bus_write(12'h004, 32'h0, 4'hF, e);
        bus_write(12'h008, 32'h0, 4'hF, e);
        bus_write(12'h000, 32'h1, 4'hF, e);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check_val($sformatf("cmp_irq_%0d", k), irq, (k == 6) ? 64'd1 : 64'd0);
        end
        bus_read(12'h010, rd, e);
        check_val("cmp_tisr_set", rd, 1);
        bus_write(12'h010, 32'h1, 4'hF, e);
        check_val("w1c_irq", irq, 0);
        bus_read(12'h010, rd, e);
        check_val("w1c_tisr", rd, 0);

        // W1C in the same cycle as a match: set wins
        bus_write(12'h000, 32'h0, 4'hF, e);
        bus_write(12'h004, 32'h5, 4'hF, e);
        bus_write(12'h010, 32'h1, 4'hF, e);
        bus_read(12'h010, rd, e);
        check_val("setwins_tisr", rd, 1);
        check_val("setwins_irq", irq, 1);
        bus_write(12'h00C, 32'h0, 4'hF, e);
        check_val("tier_mask_irq", irq, 0);
        bus_read(12'h010, rd, e);
        check_val("tier_mask_tisr", rd, 1);

        // 5. byte-strobed write
        bus_write(12'h028, 32'hAABBCCDD, 4'b0010, e);
        bus_read(12'h028, rd, e);
        check_val("strb_tcmp_lo1", rd, 32'hFFFFCCFF);

        // 6. access errors
        bus_read(12'h3FC, rd, e);
        check_val("unmapped_err", e, 1);
        check_val("unmapped_rdata", rd, 0);
        @(negedge clk);
        check_val("err_pulse_end", bus_if.err, 0);
        bus_write(12'h002, 32'h303, 4'hF, e);
        check_val("misalign_err", e, 1);
        bus_read(12'h000, rd, e);
        check_val("misalign_tcr", rd, 0);
        check_val("misalign_cnt", cnt, 5);

        @(negedge clk);
        bus_if.addr  = 12'h00C;
        bus_if.wdata = 32'h1;
        bus_if.wstrb = 4'hF;
        bus_if.wr_en = 1'b1;
        bus_if.rd_en = 1'b1;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        check_val("wrrd_err", bus_if.err, 1);
        check_val("wrrd_rdata", bus_if.rdata, 0);
        bus_read(12'h00C, rd, e);
        check_val("wrrd_tier", rd, 0);

        bus_write(12'h00C, 32'h1, 4'h0, e);
        check_val("nostrb_err", e, 0);
        bus_read(12'h00C, rd, e);
        check_val("nostrb_tier", rd, 0);

        // reset mid-count with a read in flight
        bus_write(12'h000, 32'h1, 4'hF, e);
        bus_write(12'h00C, 32'h1, 4'hF, e);
        repeat (3) @(negedge clk);
        check_val("pre_rst_irq", irq, 1);
        bus_if.addr  = 12'h020;
        bus_if.rd_en = 1'b1;
        rst          = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus_if.rd_en = 1'b0;
        check_val("midrst_rdata", bus_if.rdata, 0);
        check_val("midrst_cnt",   cnt, 0);
        check_val("midrst_irq",   irq, 0);
        check_val("midrst_err",   bus_if.err, 0);
        for (int i = 0; i < 9; i++) begin
            bus_read(map_addr[i], rd, e);
            check_val($sformatf("midrst_read_%03h", map_addr[i]), rd, map_rst[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
